// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch-target-buffer entry layout and the
// 2-bit direction counter encoding.
package rv32i_types;

    // Wide enough for the smallest table (4 entries); larger tables zero-extend.
    localparam int BTB_TAG_W = 28;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_ctr_t;

    localparam bht_ctr_t BTB_RESET_CTR = WEAK_NT;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [29:0]          target;
        bht_ctr_t             ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
    import rv32i_types::*;
(
    input  bht_ctr_t cur,
    input  logic     taken,
    output bht_ctr_t next
);

    always_comb begin
        next = cur;
        unique case (cur)
            STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  next = taken ? STRONG_T : WEAK_T;
            default:   next = cur;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped flop-based branch target buffer with combinational lookup.
// Define BTB_STATS_EN to add free-running hit/update/allocation counters.
module branch_target_buffer
    import rv32i_types::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        use_predicted,
    output logic [31:0] predicted_pc,
`ifdef BTB_STATS_EN
    output logic [31:0] stat_lookups_hit,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_allocs,
`endif
    input  logic        upd_valid,
    input  logic        upd_is_ctrl,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    btb_entry_t btb_table [ENTRIES];

    logic [IDX_BITS-1:0]  fetch_idx;
    logic [BTB_TAG_W-1:0] fetch_tag;
    btb_entry_t           fetch_entry;
    logic                 fetch_hit;

    logic [IDX_BITS-1:0]  upd_idx;
    logic [BTB_TAG_W-1:0] upd_tag;
    btb_entry_t           upd_entry;
    btb_entry_t           upd_next;
    bht_ctr_t             ctr_next;
    logic                 upd_en;
    logic                 upd_hit;
    logic                 upd_write;
    logic                 upd_alloc;

    logic unused_low_bits;
    assign unused_low_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Lookup reads pre-update state; a same-cycle write is seen next cycle.
    assign fetch_idx     = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag     = BTB_TAG_W'(fetch_pc[31:IDX_BITS+2]);
    assign fetch_entry   = btb_table[fetch_idx];
    assign fetch_hit     = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign use_predicted = fetch_hit && fetch_entry.ctr[1];
    assign predicted_pc  = use_predicted ? {fetch_entry.target, 2'b00} : 32'h0;

    assign upd_idx   = upd_pc[IDX_BITS+1:2];
    assign upd_tag   = BTB_TAG_W'(upd_pc[31:IDX_BITS+2]);
    assign upd_entry = btb_table[upd_idx];
    assign upd_en    = upd_valid && upd_is_ctrl;
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign upd_alloc = upd_en && !upd_hit && upd_taken;
    assign upd_write = upd_en && (upd_hit || upd_taken);

    sat_counter2 u_ctr (
        .cur   (upd_entry.ctr),
        .taken (upd_taken),
        .next  (ctr_next)
    );

    always_comb begin
        upd_next = upd_entry;
        if (upd_hit) begin
            upd_next.ctr = ctr_next;
            if (upd_taken) upd_next.target = upd_target[31:2];
        end else begin
            upd_next.valid  = 1'b1;
            upd_next.tag    = upd_tag;
            upd_next.target = upd_target[31:2];
            upd_next.ctr    = WEAK_T;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_table[i].valid <= 1'b0;
                btb_table[i].ctr   <= BTB_RESET_CTR;
            end
        end else if (upd_write) begin
            btb_table[upd_idx] <= upd_next;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups_hit <= 32'h0;
            stat_updates     <= 32'h0;
            stat_allocs      <= 32'h0;
        end else begin
            if (use_predicted) stat_lookups_hit <= stat_lookups_hit + 32'd1;
            if (upd_en)        stat_updates     <= stat_updates + 32'd1;
            if (upd_alloc)     stat_allocs      <= stat_allocs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (ENTRIES=64): directed
// scenarios plus random training against an array-based reference model.
module tb_branch_target_buffer;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        use_predicted;
    logic [31:0] predicted_pc;
    logic        upd_valid;
    logic        upd_is_ctrl;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_hit;
    logic [31:0] stat_updates;
    logic [31:0] stat_allocs;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per table slot.
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    logic [31:0] m_hits, m_upds, m_allocs;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .use_predicted (use_predicted),
        .predicted_pc  (predicted_pc),
`ifdef BTB_STATS_EN
        .stat_lookups_hit (stat_lookups_hit),
        .stat_updates     (stat_updates),
        .stat_allocs      (stat_allocs),
`endif
        .upd_valid     (upd_valid),
        .upd_is_ctrl   (upd_is_ctrl),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_pred(input logic [31:0] pc);
        int unsigned i;
        i = (pc / 4) % N;
        return m_valid[i] && (m_tag[i] == pc / (4 * N)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] model_pc(input logic [31:0] pc);
        return model_pred(pc) ? (m_target[(pc / 4) % N] & 32'hFFFF_FFFC) : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_hits = 0; m_upds = 0; m_allocs = 0;
    endtask

    task automatic model_clock();
        int unsigned i;
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        if (model_pred(fetch_pc)) m_hits++;
        if (!(upd_valid && upd_is_ctrl)) return;
        m_upds++;
        i   = (upd_pc / 4) % N;
        hit = m_valid[i] && (m_tag[i] == upd_pc / (4 * N));
        if (hit) begin
            if (upd_taken) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_target[i] = upd_target;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (upd_taken) begin
            m_valid[i]  = 1;
            m_tag[i]    = upd_pc / (4 * N);
            m_target[i] = upd_target;
            m_ctr[i]    = 2;
            m_allocs++;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".use"}, {31'b0, use_predicted}, {31'b0, model_pred(fetch_pc)});
        check({tag, ".ppc"}, predicted_pc, model_pc(fetch_pc));
`ifdef BTB_STATS_EN
        check({tag, ".st_hit"}, stat_lookups_hit, m_hits);
        check({tag, ".st_upd"}, stat_updates, m_upds);
        check({tag, ".st_alloc"}, stat_allocs, m_allocs);
`endif
    endtask

    // Drive one cycle's inputs, check lookup (pre-edge) against the model,
    // optionally against literal expectations, then clock.
    task automatic step(input string tag, input logic r, input logic uv, input logic uc,
                        input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                        input logic [31:0] fpc, input bit chk, input logic eu,
                        input logic [31:0] epc);
        rst = r; upd_valid = uv; upd_is_ctrl = uc; upd_pc = upc;
        upd_taken = tk; upd_target = tgt; fetch_pc = fpc;
        #1;
        check_model(tag);
        if (chk) begin
            check({tag, ".use_k"}, {31'b0, use_predicted}, {31'b0, eu});
            check({tag, ".ppc_k"}, predicted_pc, epc);
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] fpc, input logic eu, input logic [31:0] epc);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fpc, 1'b1, eu, epc);
    endtask

    task automatic train(input string tag, input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                         input logic [31:0] fpc, input logic eu, input logic [31:0] epc);
        step(tag, 1'b0, 1'b1, 1'b1, upc, tk, tgt, fpc, 1'b1, eu, epc);
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b1; upd_valid = 0; upd_is_ctrl = 0; upd_pc = 0;
        upd_taken = 0; upd_target = 0; fetch_pc = 0;
        model_reset();
        @(posedge clk); #1;
        step("rst", 1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h60, 1'b0, 1'b0, 0);

        look("after_rst", 32'h60, 1'b0, 32'h0);

        // First taken training with a same-cycle lookup of that PC.
        train("same_cycle", 32'h100, 1'b1, 32'h200, 32'h100, 1'b0, 32'h0);
        look("t2_hit", 32'h100, 1'b1, 32'h200);

        train("nt1", 32'h100, 1'b0, 32'h0, 32'h100, 1'b1, 32'h200);
        look("ctr01", 32'h100, 1'b0, 32'h0);
        train("nt2", 32'h100, 1'b0, 32'h0, 32'h100, 1'b0, 32'h0);
        train("tk_from00", 32'h100, 1'b1, 32'h200, 32'h100, 1'b0, 32'h0);
        look("ctr01_again", 32'h100, 1'b0, 32'h0);

        // Aliasing: 0x100 and 0x200 share index 0.
        train("re1", 32'h100, 1'b1, 32'h200, 32'h60, 1'b0, 32'h0);
        train("re2", 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 32'h200);
        look("alias_miss", 32'h200, 1'b0, 32'h0);
        train("alias_alloc", 32'h200, 1'b1, 32'h400, 32'h200, 1'b0, 32'h0);
        look("alias_old", 32'h100, 1'b0, 32'h0);
        look("alias_new", 32'h200, 1'b1, 32'h400);

        // jalr with misaligned target, then saturation and one step back.
        train("jalr", 32'h80, 1'b1, 32'h1003, 32'h80, 1'b0, 32'h0);
        look("jalr_pc", 32'h80, 1'b1, 32'h1000);
        for (int k = 0; k < 3; k++)
            train("sat_up", 32'h80, 1'b1, 32'h1003, 32'h80, 1'b1, 32'h1000);
        train("sat_dn", 32'h80, 1'b0, 32'h0, 32'h80, 1'b1, 32'h1000);
        look("ctr10", 32'h80, 1'b1, 32'h1000);

        // Non-control and invalid updates must not train.
        step("not_ctrl", 1'b0, 1'b1, 1'b0, 32'h300, 1'b1, 32'h500, 32'h300, 1'b1, 1'b0, 0);
        step("not_valid", 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h500, 32'h300, 1'b1, 1'b0, 0);
        look("no_train", 32'h300, 1'b0, 32'h0);

        // Reset wins over a concurrent update.
        step("rst_upd", 1'b1, 1'b1, 1'b1, 32'h340, 1'b1, 32'h700, 32'h340, 1'b0, 1'b0, 0);
        look("rst_upd_inv", 32'h340, 1'b0, 32'h0);
        look("rst_cleared", 32'h80, 1'b0, 32'h0);

        // Random training over a small address pool to force hits and aliases.
        for (int n = 0; n < 2000; n++) begin
            rpc = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
            step("rand",
                 1'b0 || ($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                 {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00, 2'($urandom)},
                 1'($urandom), $urandom, rpc, 1'b0, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-side branch predictor feeding the IF stage's use_predicted / predicted_pc inputs.
- Direct-mapped table: tag, word-aligned target, and 2-bit saturating direction counter per entry.
- Looked up combinationally on the current fetch PC.
- Trained one entry per cycle from the resolved control-flow outcome in EX.

Parameters:
- ENTRIES, 64, number of table entries; power of two, 4 to 1024.
- IDX_BITS, $clog2(ENTRIES), index width, derived; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fetch_pc  in  32  current IF PC (pc_out).
- use_predicted  out  1  redirect fetch to predicted_pc.
- predicted_pc  out  32  predicted next PC, low 2 bits always 0.
- upd_valid  in  1  EX holds a resolved instruction this cycle.
- upd_is_ctrl  in  1  that instruction is a branch, jal or jalr.
- upd_pc  in  32  PC of the EX instruction (pc_out_ex).
- upd_taken  in  1  resolved direction (br_en, or 1 for jal/jalr).
- upd_target  in  32  resolved target (branch_pc_ex).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports clk and rst.
- Address split: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target[31:2], ctr[1:0].
- Lookup (combinational from current state):
  - hit = valid[idx] & tag match.
  - use_predicted = hit & ctr[1].
  - predicted_pc = {target,2'b00} when use_predicted, else 32'h0.
- Update, at the clock edge when upd_valid & upd_is_ctrl:
  - Tag hit, taken: ctr saturating increment (11 stays 11); target <= upd_target[31:2].
  - Tag hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Tag miss or invalid, taken: allocate; valid=1, tag, target, ctr=2'b10 (weakly taken). Replaces any aliasing entry.
  - Tag miss, not taken: no change.
- upd_valid=0 or upd_is_ctrl=0: no state change.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents; the new state is visible the next cycle. No bypass.
- Stalls: none exposed. Updates are gated only by upd_valid, so EX must deassert upd_valid while stalled to avoid double training.
- Reset:
  - All valid <= 0, all ctr <= 2'b01; tags and targets don't-care.
  - use_predicted = 0 and predicted_pc = 0 in the cycle after reset.
  - Reset asserted together with an update: reset wins, update discarded.
- Latency: lookup 0 cycles; update visible 1 cycle after the training edge.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds outputs stat_lookups_hit[31:0], stat_updates[31:0], stat_allocs[31:0].
  - stat_lookups_hit increments each cycle use_predicted=1.
  - stat_updates increments each training update.
  - stat_allocs increments each allocation.
  - Counters are free-running, wrap at 2^32, and reset to 0.
- Undefined: these ports and their logic are absent; prediction behaviour is identical.

Decomposition:
- Shared package rv32i_types gains:
  - typedef btb_entry_t (packed: valid, tag, target, ctr).
  - enum bht_ctr_t: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - localparam BTB_RESET_CTR = WEAK_NT.
- One sub-module, sat_counter2: combinational next-state for the 2-bit saturating counter (inputs cur, taken; output next).
- Table storage is flip-flops, not SRAM, to allow the combinational read.

Test Plan (ENTRIES=64):
- Reset, then fetch_pc=32'h60 -> use_predicted=0, predicted_pc=0.
- Update upd_pc=32'h100, taken, target 32'h200; next cycle fetch_pc=32'h100 -> use_predicted=1, predicted_pc=32'h200.
- Following test 2, one not-taken update at 32'h100 -> ctr=01, use_predicted=0. Second not-taken -> ctr=00. Then one taken -> ctr=01, still 0.
- Alias: 32'h100 trained taken, fetch_pc=32'h200 (same idx 0, different tag) -> use_predicted=0. Then taken update at 32'h200, target 32'h400 -> fetch 32'h100 gives 0, fetch 32'h200 gives 32'h400.
- jalr update at upd_pc=32'h80, target 32'h1003 -> predicted_pc=32'h1000. Three more taken updates then one not-taken -> ctr=10, still predicts 32'h1000.
- fetch_pc=32'h100 while the first taken update of 32'h100 occurs in the same cycle -> use_predicted=0 that cycle, 1 the next. Reset asserted concurrently with an update -> entry remains invalid.
